// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified I/D memory between the
// multicycle core (requester 0) and the program loader / debug port
// (requester 1). Round-robin grant, one access in flight, a one-cycle ack
// per completed access, and a combinational stall back to the core.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_mode,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          core_stall,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Read data is captured on the last ACCESS cycle of a read.
    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          winner_q, winner_d;
    logic          last_grant_q, last_grant_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          elig0, elig1, pick;

    // Next-state logic: arbitrate in IDLE, sequence the access, pulse the ack.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;

        // The core is locked out while the loader owns memory.
        elig0 = req0 & ~boot_mode;
        elig1 = req1;
        // On a tie the requester that did not win last time goes next.
        pick  = (elig0 & elig1) ? ~last_grant_q : elig1;

        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    winner_d    = pick;
                    mem_we_d    = pick ? we1 : we0;
                    mem_addr_d  = pick ? addr1 : addr0;
                    mem_wdata_d = pick ? wdata1 : wdata0;
                    mem_en_d    = 1'b1;
                    cnt_d       = 2'd0;
                    state_d     = ACCESS;
                end else begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                end
            end
            ACCESS: begin
                // Writes take a single cycle; reads wait out the memory latency.
                if (mem_we_q || (cnt_q == CNT_LAST)) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack0_d   = ~winner_q;
                    ack1_d   = winner_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign busy       = busy_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rdata      = rdata_q;
    assign core_stall = req0 & ~ack0_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) driven
// by a short directed prelude followed by random requesters, checked every
// cycle against a transaction-schedule model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          boot_mode [2];
    logic          req0 [2], we0 [2], req1 [2], we1 [2];
    logic [AW-1:0] addr0 [2], addr1 [2], mem_addr [2];
    logic [DW-1:0] wdata0 [2], wdata1 [2], rdata [2], mem_wdata [2], mem_rdata [2];
    logic          ack0 [2], ack1 [2], core_stall [2], busy [2], mem_en [2], mem_we [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .boot_mode  (boot_mode[g]),
            .req0       (req0[g]),
            .we0        (we0[g]),
            .addr0      (addr0[g]),
            .wdata0     (wdata0[g]),
            .ack0       (ack0[g]),
            .req1       (req1[g]),
            .we1        (we1[g]),
            .addr1      (addr1[g]),
            .wdata1     (wdata1[g]),
            .ack1       (ack1[g]),
            .rdata      (rdata[g]),
            .core_stall (core_stall[g]),
            .busy       (busy[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit in_rst;
    bit directed;

    // Reference model: one scheduled transaction per instance.
    bit          act [2];
    int          st [2], dur [2], nxt [2];
    bit          twe [2], tid [2], lastg [2];
    logic [31:0] taddr [2], twd [2], trd [2], exp_rd [2];
    bit          outst [2][2];
    int          age [2];
    bit          prev_en [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0051_0513;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic set_req(input int i, input int r, input logic rq, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (r == 0) begin
            req0[i] = rq; we0[i] = w; addr0[i] = a; wdata0[i] = d;
        end else begin
            req1[i] = rq; we1[i] = w; addr1[i] = a; wdata1[i] = d;
        end
    endtask

    task automatic issue(input int i, input int r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        set_req(i, r, 1'b1, w, a, d);
        outst[i][r] = 1'b1;
    endtask

    task automatic drop_req(input int i, input int r);
        if (r == 0) req0[i] = 1'b0;
        else        req1[i] = 1'b0;
    endtask

    function automatic logic get_req(input int i, input int r);
        return (r == 0) ? req0[i] : req1[i];
    endfunction

    task automatic model_reset(input int i);
        act[i]    = 1'b0;
        lastg[i]  = 1'b1;
        exp_rd[i] = '0;
        age[i]    = 0;
        for (int r = 0; r < 2; r++)
            if (outst[i][r] && !get_req(i, r)) outst[i][r] = 1'b0;
    endtask

    // Advance the model across clock edge number cyc.
    task automatic model_edge(input int i);
        bit e0, e1, g;
        if (act[i] && cyc == st[i] + dur[i] && !twe[i]) exp_rd[i] = trd[i];
        if (act[i] && cyc == st[i] + dur[i] + 1) begin
            act[i]   = 1'b0;
            lastg[i] = tid[i];
        end
        if (cyc >= nxt[i]) begin
            e0 = req0[i] && !boot_mode[i];
            e1 = req1[i];
            if (e0 || e1) begin
                g        = (e0 && e1) ? !lastg[i] : e1;
                act[i]   = 1'b1;
                st[i]    = cyc;
                tid[i]   = g;
                twe[i]   = g ? we1[i] : we0[i];
                taddr[i] = g ? addr1[i] : addr0[i];
                twd[i]   = g ? wdata1[i] : wdata0[i];
                trd[i]   = memf(taddr[i]);
                dur[i]   = twe[i] ? 1 : lat(i);
                nxt[i]   = cyc + dur[i] + 2;
            end else begin
                nxt[i] = cyc + 1;
            end
        end
    endtask

    task automatic check_cycle(input int i);
        bit en_e, ack_e, busy_e;
        string p;
        p      = $sformatf("L%0d", lat(i));
        en_e   = act[i] && cyc < st[i] + dur[i];
        ack_e  = act[i] && cyc == st[i] + dur[i];
        busy_e = act[i] && cyc <= st[i] + dur[i];
        chk({p, " ack0"},   {31'b0, ack0[i]},   {31'b0, ack_e && tid[i] == 1'b0});
        chk({p, " ack1"},   {31'b0, ack1[i]},   {31'b0, ack_e && tid[i] == 1'b1});
        chk({p, " mem_en"}, {31'b0, mem_en[i]}, {31'b0, en_e});
        chk({p, " mem_we"}, {31'b0, mem_we[i]}, {31'b0, en_e && twe[i]});
        chk({p, " busy"},   {31'b0, busy[i]},   {31'b0, busy_e});
        chk({p, " rdata"},  rdata[i], exp_rd[i]);
        chk({p, " core_stall"}, {31'b0, core_stall[i]},
            {31'b0, req0[i] && !(ack_e && tid[i] == 1'b0)});
        if (en_e) chk({p, " mem_addr"}, mem_addr[i], taddr[i]);
        if (en_e && twe[i]) chk({p, " mem_wdata"}, mem_wdata[i], twd[i]);
    endtask

    task automatic check_reset_outputs(input int i);
        string p;
        p = $sformatf("L%0d rst", lat(i));
        chk({p, " ack0"},      {31'b0, ack0[i]},   32'd0);
        chk({p, " ack1"},      {31'b0, ack1[i]},   32'd0);
        chk({p, " mem_en"},    {31'b0, mem_en[i]}, 32'd0);
        chk({p, " mem_we"},    {31'b0, mem_we[i]}, 32'd0);
        chk({p, " busy"},      {31'b0, busy[i]},   32'd0);
        chk({p, " mem_addr"},  mem_addr[i],  32'd0);
        chk({p, " mem_wdata"}, mem_wdata[i], 32'd0);
        chk({p, " rdata"},     rdata[i],     32'd0);
    endtask

    task automatic drive_requesters(input int i);
        bit ack_e, gw;
        for (int r = 0; r < 2; r++) begin
            ack_e = act[i] && cyc == st[i] + dur[i] && tid[i] == r[0];
            gw    = act[i] && cyc < st[i] + dur[i] && tid[i] == r[0];
            if (ack_e) begin
                outst[i][r] = 1'b0;
                if (!directed && $urandom_range(1, 0) == 1)
                    issue(i, r, $urandom_range(1, 0) == 1, {$urandom_range(255, 0), 2'b00}, $urandom);
                else
                    drop_req(i, r);
            end else if (outst[i][r] && gw && get_req(i, r) && $urandom_range(7, 0) == 0) begin
                drop_req(i, r);
            end else if (!outst[i][r] && !directed && $urandom_range(3, 0) == 0) begin
                issue(i, r, $urandom_range(1, 0) == 1, {$urandom_range(255, 0), 2'b00}, $urandom);
            end
        end
        if (!directed && $urandom_range(49, 0) == 0) boot_mode[i] = !boot_mode[i];
    endtask

    // Memory responder: correct data only on the last cycle of the latency window.
    task automatic drive_memory(input int i);
        if (mem_en[i]) age[i] = prev_en[i] ? age[i] + 1 : 0;
        else           age[i] = 0;
        prev_en[i] = mem_en[i];
        if (mem_en[i] && age[i] == lat(i) - 1) mem_rdata[i] = memf(mem_addr[i]);
        else                                   mem_rdata[i] = $urandom;
    endtask

    initial begin
        rst_n  = 1'b0;
        in_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            boot_mode[i] = 1'b0;
            set_req(i, 0, 1'b0, 1'b0, '0, '0);
            set_req(i, 1, 1'b0, 1'b0, '0, '0);
            mem_rdata[i] = '0;
            outst[i][0] = 1'b0;
            outst[i][1] = 1'b0;
            prev_en[i]  = 1'b0;
            nxt[i]      = 0;
            model_reset(i);
        end
        #2;
        for (int i = 0; i < 2; i++) check_reset_outputs(i);

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            cyc++;
            directed = (cyc < 40);
            if (!in_rst)
                for (int i = 0; i < 2; i++) model_edge(i);
            #1;
            for (int i = 0; i < 2; i++) check_cycle(i);
            if (in_rst) begin
                rst_n  = 1'b1;
                in_rst = 1'b0;
                for (int i = 0; i < 2; i++) nxt[i] = cyc + 1;
            end

            for (int i = 0; i < 2; i++) begin
                if (directed) begin
                    if (cyc == 1)  issue(i, 0, 1'b0, 32'h0000_0010, 32'h0);
                    if (cyc == 6)  issue(i, 1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
                    if (cyc == 12) begin
                        issue(i, 0, 1'b0, 32'h0000_0020, 32'h0);
                        issue(i, 1, 1'b0, 32'h0000_0024, 32'h0);
                    end
                    if (cyc == 30) issue(i, 1, 1'b1, 32'h0000_0044, 32'h1234_5678);
                end
                drive_requesters(i);
            end

            for (int i = 0; i < 2; i++) drive_memory(i);

            // Reset mid-cycle: once during the directed loader write, then at random.
            if (cyc == 31 || (!directed && $urandom_range(199, 0) == 0)) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    check_reset_outputs(i);
                    model_reset(i);
                    prev_en[i] = 1'b0;
                end
                in_rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
